// File: rtl/decim_pkg.sv
// Shared types and width helpers for the decimating averager.
package decim_pkg;

  typedef logic signed [15:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with an occupancy counter.
// Writes to a full FIFO are accepted only together with a pop.
module sync_fifo_fwft
  import decim_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(1);
      if (rd_en) rptr <= rptr + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/decim_avg.sv
// Accumulate-and-dump averager over 2**DECIM_LOG2 samples feeding an FWFT FIFO.
// Define DECIM_AVG_ROUND_EN for round-half-up instead of floor.
module decim_avg
  import decim_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            en_i,
  input  logic signed [DATA_W-1:0]        data_i,
  output logic signed [DATA_W-1:0]        data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     level_o,
  output logic                            overflow_o,
  input  logic                            clr_ovf_i
);

`ifdef DECIM_AVG_ROUND_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif

  localparam int AW  = DATA_W + DECIM_LOG2 + GUARD;
  localparam int CW  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int N   = 1 << DECIM_LOG2;
  localparam int BSH = (DECIM_LOG2 > 0) ? DECIM_LOG2 - 1 : 0;
  localparam logic signed [AW-1:0] BIAS =
    (GUARD != 0 && DECIM_LOG2 > 0) ? AW'(1 << BSH) : '0;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] rsum;
  logic signed [AW-1:0] shifted;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 push;
  logic                 drop;
  logic                 full;
  logic                 empty;
  logic [DATA_W-1:0]    result;
  logic [DATA_W-1:0]    head;

  assign last    = (cnt == CW'(N - 1));
  assign sum     = acc + AW'(data_i);
  assign rsum    = sum + BIAS;
  assign shifted = rsum >>> DECIM_LOG2;
  assign result  = shifted[DATA_W-1:0];
  assign push    = en_i && last;

  // a full FIFO still takes the result when the consumer pops this cycle
  assign drop    = push && full && !ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (en_i) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)        overflow_o <= 1'b0;
    else if (drop)      overflow_o <= 1'b1;
    else if (clr_ovf_i) overflow_o <= 1'b0;
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (reset_i),
    .push  (push && !drop),
    .din   (result),
    .pop   (ready_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

  assign data_o  = head;
  assign valid_o = !empty;

endmodule

// File: tb/tb_decim_avg.sv
// Scoreboard bench for decim_avg (N=4 instance plus a DECIM_LOG2=0 instance).
module tb_decim_avg;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [15:0] din;
  logic signed [15:0] dout;
  logic               valid;
  logic               ready;
  logic [2:0]         level;
  logic               ovf;
  logic               clr;

  logic               en2;
  logic signed [15:0] din2;
  logic signed [15:0] dout2;
  logic               valid2;
  logic               ready2;
  logic [2:0]         level2;
  logic               ovf2;

  int cmp = 0;
  int err = 0;
  int q[$];
  int e_mon;

  always #5 clk = ~clk;

  decim_avg #(.DATA_W(16), .DECIM_LOG2(2), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .reset_i(rst), .en_i(en), .data_i(din),
    .data_o(dout), .valid_o(valid), .ready_i(ready),
    .level_o(level), .overflow_o(ovf), .clr_ovf_i(clr)
  );

  decim_avg #(.DATA_W(16), .DECIM_LOG2(0), .FIFO_DEPTH(4)) dut0 (
    .clk_i(clk), .reset_i(rst), .en_i(en2), .data_i(din2),
    .data_o(dout2), .valid_o(valid2), .ready_i(ready2),
    .level_o(level2), .overflow_o(ovf2), .clr_ovf_i(1'b0)
  );

  // floor division by 4, independent of any shift arithmetic
  function automatic int fdiv4(input int s);
    int r;
    r = s / 4;
    if ((s % 4 != 0) && (s < 0)) r = r - 1;
    return r;
  endfunction

  function automatic int model(input int s);
`ifdef DECIM_AVG_ROUND_EN
    return fdiv4(s + 2);
`else
    return fdiv4(s);
`endif
  endfunction

  // every accepted handshake is checked against the scoreboard head
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      cmp++;
      if (q.size() == 0) begin
        err++;
        $display("FAIL sb_unexpected got=%0d required=none", dout);
      end else begin
        e_mon = q.pop_front();
        if (dout !== e_mon[15:0]) begin
          err++;
          $display("FAIL sb_data got=%0d required=%0d", dout, e_mon);
        end
      end
    end
  end

  task automatic put(input int v);
    en  = 1'b1;
    din = 16'(v);
    @(posedge clk);
    #1;
    en  = 1'b0;
  endtask

  task automatic group(input int a, input int b, input int c,
                       input int d, input bit keep, input bit lat);
    int e;
    e = model(a + b + c + d);
    if (keep) q.push_back(e);
    put(a);
    put(b);
    put(c);
    if (lat) begin
      cmp++;
      if (valid !== 1'b0) begin
        err++;
        $display("FAIL early_valid got=%b required=0", valid);
      end
    end
    put(d);
    if (lat) begin
      cmp++;
      if (valid !== 1'b1 || dout !== e[15:0]) begin
        err++;
        $display("FAIL latency got=%b/%0d required=1/%0d", valid, dout, e);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && (q.size() != 0 || valid); i++) begin
      @(posedge clk);
      #1;
    end
    cmp++;
    if (q.size() != 0 || valid !== 1'b0) begin
      err++;
      $display("FAIL drain_%s got=%0d pending/valid=%b required=0/0",
               name, q.size(), valid);
    end
  endtask

  task automatic test_reset;
    cmp++;
    if (dout !== 16'sd0 || valid !== 1'b0 || level !== 3'd0 || ovf !== 1'b0) begin
      err++;
      $display("FAIL reset got=%0d/%b/%0d/%b required=0/0/0/0",
               dout, valid, level, ovf);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    ready = 1'b0;
    group(1, 1, 1, 1, 1'b1, 1'b0);
    put(3);
    put(5);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    cmp++;
    if (dout !== 16'sd0 || valid !== 1'b0 || level !== 3'd0) begin
      err++;
      $display("FAIL reset_async got=%0d/%b/%0d required=0/0/0",
               dout, valid, level);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ready = 1'b1;
    group(4, 4, 4, 4, 1'b1, 1'b1);
    wait_drain("reset_mid");
  endtask

  task automatic test_average;
    group(1, 2, 3, 4, 1'b1, 1'b1);
    wait_drain("average");
  endtask

  task automatic test_extremes;
    group(-1, -2, -2, -2, 1'b1, 1'b1);
    wait_drain("neg");
    group(32767, 32767, 32767, 32767, 1'b1, 1'b1);
    wait_drain("max");
    group(-32768, -32768, -32768, -32768, 1'b1, 1'b1);
    wait_drain("min");
  endtask

  task automatic test_backpressure;
    ready = 1'b0;
    group(10, 10, 10, 10, 1'b1, 1'b0);
    group(20, 20, 20, 20, 1'b1, 1'b0);
    group(-8, -8, -8, -9, 1'b1, 1'b0);
    group(100, 101, 102, 103, 1'b1, 1'b0);
    group(7, 7, 7, 7, 1'b0, 1'b0);
    cmp++;
    if (level !== 3'd4 || ovf !== 1'b1) begin
      err++;
      $display("FAIL overflow got=%0d/%b required=4/1", level, ovf);
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    cmp++;
    if (ovf !== 1'b0 || level !== 3'd4) begin
      err++;
      $display("FAIL clr_ovf got=%b/%0d required=0/4", ovf, level);
    end
  endtask

  task automatic test_push_pop_full;
    q.push_back(model(200));
    put(50);
    put(50);
    put(50);
    ready = 1'b1;
    put(50);
    ready = 1'b0;
    cmp++;
    if (level !== 3'd4 || ovf !== 1'b0) begin
      err++;
      $display("FAIL push_pop_full got=%0d/%b required=4/0", level, ovf);
    end
    ready = 1'b1;
    wait_drain("full");
  endtask

  task automatic test_gaps;
    int s[8] = '{9, -3, 14, 2, -100, 55, 0, -1};
    q.push_back(model(9 - 3 + 14 + 2));
    q.push_back(model(-100 + 55 + 0 - 1));
    foreach (s[i]) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      put(s[i]);
    end
    wait_drain("gaps");
  endtask

  task automatic test_passthrough;
    en2  = 1'b1;
    din2 = -16'sd7;
    @(posedge clk);
    #1;
    en2  = 1'b0;
    cmp++;
    if (valid2 !== 1'b1 || dout2 !== -16'sd7 || level2 !== 3'd1) begin
      err++;
      $display("FAIL pass_through got=%b/%0d/%0d required=1/-7/1",
               valid2, dout2, level2);
    end
    @(posedge clk);
    #1;
    cmp++;
    if (valid2 !== 1'b0 || level2 !== 3'd0) begin
      err++;
      $display("FAIL pass_pop got=%b/%0d required=0/0", valid2, level2);
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    din    = '0;
    ready  = 1'b1;
    clr    = 1'b0;
    en2    = 1'b0;
    din2   = '0;
    ready2 = 1'b1;
    #12;
    test_reset;
    test_reset_mid;
    test_average;
    test_extremes;
    test_backpressure;
    test_push_pop_full;
    test_gaps;
    test_passthrough;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
